// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one handshake-wrapped adder among N_REQ requesters
// Define ADDER_ARB_RR_EN for round-robin arbitration; otherwise the lowest asserted index wins.
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic [N_REQ-1:0]         resp_ready,
    output logic [WIDTH:0]           resp_data,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [WIDTH:0]           res_data,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT_RES,
        DELIVER
    } state_t;

    state_t            state, state_d;
    logic [N_REQ-1:0]  req_ready_d, resp_valid_d;
    logic [WIDTH:0]    resp_data_d;
    logic              op_valid_d, res_ready_d, busy_d;
    logic [WIDTH-1:0]  op_a_d, op_b_d;
    logic [GW-1:0]     grant_id_d;
    logic [GW-1:0]     winner;
    logic              any_req;

`ifdef ADDER_ARB_RR_EN
    logic [GW-1:0]     last, last_d;

    // Scan offsets from farthest to nearest so the nearest valid index after last wins.
    always_comb begin
        int idx;
        winner  = '0;
        any_req = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (req_valid[idx]) begin
                winner  = GW'(idx);
                any_req = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner  = GW'(i);
                any_req = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d      = state;
        req_ready_d  = req_ready;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        op_valid_d   = op_valid;
        res_ready_d  = res_ready;
        op_a_d       = op_a;
        op_b_d       = op_b;
        grant_id_d   = grant_id;
`ifdef ADDER_ARB_RR_EN
        last_d       = last;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_id_d  = winner;
                    req_ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                req_ready_d = '0;
                if (req_valid[grant_id]) begin
                    op_a_d     = req_a[int'(grant_id)*WIDTH +: WIDTH];
                    op_b_d     = req_b[int'(grant_id)*WIDTH +: WIDTH];
                    op_valid_d = 1'b1;
                    state_d    = ISSUE;
                end else begin
                    // Requester withdrew before handing over operands: no pointer update.
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (op_valid && op_ready) begin
                    op_valid_d  = 1'b0;
                    res_ready_d = 1'b1;
                    state_d     = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid && res_ready) begin
                    resp_data_d  = res_data;
                    res_ready_d  = 1'b0;
                    resp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                    state_d      = DELIVER;
                end
            end
            DELIVER: begin
                if (resp_valid[grant_id] && resp_ready[grant_id]) begin
                    resp_valid_d = '0;
`ifdef ADDER_ARB_RR_EN
                    last_d       = grant_id;
`endif
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            op_valid   <= 1'b0;
            res_ready  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
`ifdef ADDER_ARB_RR_EN
            last       <= GW'(N_REQ - 1);
`endif
        end else begin
            state      <= state_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            op_valid   <= op_valid_d;
            res_ready  <= res_ready_d;
            op_a       <= op_a_d;
            op_b       <= op_b_d;
            grant_id   <= grant_id_d;
            busy       <= busy_d;
`ifdef ADDER_ARB_RR_EN
            last       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed bench for adder_arbiter
module tb_adder_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [127:0] req_a, req_b;
    logic [32:0]  resp_data, res_data;
    logic         op_valid, op_ready, res_valid, res_ready, busy;
    logic [31:0]  op_a, op_b;
    logic [1:0]   grant_id;
    logic         op_en, res_en;

    int tests = 0;
    int fails = 0;

    int          got_id[8];
    int          got_t[8];
    logic [32:0] got_data[8];

    always #5 clk = ~clk;

    // Ideal adder stand-in
    assign op_ready  = op_en;
    assign res_valid = res_en;
    assign res_data  = {1'b0, op_a} + {1'b0, op_b};

    adder_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] sum;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic [32:0] psum[4];
    int          exp_all[5];
    int          exp_pri[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if ($countones(req_ready) > 1 || $countones(resp_valid) > 1 ||
                (int'(op_valid) + int'(res_ready) + int'(|resp_valid)) > 1) begin
                fails++;
                $display("FAIL mutex: req_ready=%b resp_valid=%b op_valid=%b res_ready=%b",
                         req_ready, resp_valid, op_valid, res_ready);
            end
        end
    end

    task automatic load_all();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = pa[i];
            req_b[i*32 +: 32] = pb[i];
        end
    endtask

    task automatic collect(input int n);
        int k;
        k = 0;
        for (int c = 0; c < 300 && k < n; c++) begin
            @(posedge clk); #1;
            if (resp_valid != 4'b0) begin
                for (int j = 0; j < 4; j++) if (resp_valid[j]) got_id[k] = j;
                got_data[k] = resp_data;
                got_t[k]    = c;
                k++;
            end
        end
        check("collect_count", k, n);
    endtask

    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [32:0] sum);
        int cnt;
        logic [3:0] oh;
        cnt = 0;
        oh  = 4'b0001 << idx;
        req_a = '0;
        req_b = '0;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid = oh;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) check("vec_req_ready", req_ready, oh);
            if (c == 2) begin
                check("vec_op_valid", op_valid, 1);
                req_valid = 4'b0;
            end
            if (resp_valid != 4'b0) begin
                cnt = c;
                break;
            end
        end
        check("vec_latency", cnt, 4);
        check("vec_resp_valid", resp_valid, oh);
        check("vec_resp_data", resp_data, sum);
        check("vec_grant_id", grant_id, idx);
        @(posedge clk); #1;
        check("vec_idle_busy", busy, 0);
    endtask

    initial begin
        int bad;
        int c;
        logic [32:0] held;

        vecs[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
        vecs[1] = '{0, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
        vecs[2] = '{3, 32'h1234_5678, 32'h9ABC_DEF0, 33'h0_ACF1_3568};
        vecs[3] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
        vecs[4] = '{2, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
        pa[0] = 32'h0000_0010; pb[0] = 32'h0000_0005; psum[0] = 33'h0_0000_0015;
        pa[1] = 32'hFFFF_FFF0; pb[1] = 32'h0000_0020; psum[1] = 33'h1_0000_0010;
        pa[2] = 32'h7FFF_FFFF; pb[2] = 32'h7FFF_FFFF; psum[2] = 33'h0_FFFF_FFFE;
        pa[3] = 32'h1111_1111; pb[3] = 32'h2222_2222; psum[3] = 33'h0_3333_3333;
`ifdef ADDER_ARB_RR_EN
        exp_all = '{0, 1, 2, 3, 0};
        exp_pri = '{0, 1, 0, 1};
`else
        exp_all = '{0, 0, 0, 0, 0};
        exp_pri = '{0, 0, 0, 0};
`endif

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        resp_ready = 4'hF; op_en = 1'b1; res_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_op_ab", {op_a, op_b}, 0);

        // All four requesters valid straight out of reset
        load_all();
        req_valid = 4'hF;
        rst_n = 1'b1;
        collect(5);
        req_valid = 4'h0;
        for (int k = 0; k < 5; k++) begin
            check("all_order", got_id[k], exp_all[k]);
            check("all_data", got_data[k], psum[exp_all[k]]);
            if (k > 0) check("all_spacing", got_t[k] - got_t[k-1], 5);
        end
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) run_one(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sum);

        // Adder stalls operand acceptance for 10 cycles
        op_en = 1'b0;
        resp_ready = 4'b1101;
        req_a = '0; req_b = '0;
        req_a[32 +: 32] = 32'hA5A5_A5A5;
        req_b[32 +: 32] = 32'h5A5A_5A5A;
        req_a[96 +: 32] = pa[3];
        req_b[96 +: 32] = pb[3];
        req_valid = 4'b0010;
        for (c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (op_valid) break;
        end
        check("stall_op_valid_seen", op_valid, 1);
        req_valid = 4'b1000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!op_valid || op_a !== 32'hA5A5_A5A5 || op_b !== 32'h5A5A_5A5A ||
                !busy || req_ready !== 4'b0) bad++;
        end
        check("issue_stall_stable", bad, 0);
        op_en = 1'b1;
        for (c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (resp_valid != 4'b0) break;
        end
        check("stall_resp_valid", resp_valid, 4'b0010);
        check("stall_resp_data", resp_data, 33'h0_FFFF_FFFF);

        // Requester 1 withholds resp_ready while requester 3 waits
        held = resp_data;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 4'b0010 || req_ready !== 4'b0 || resp_data !== held) bad++;
        end
        check("deliver_stall_stable", bad, 0);
        resp_ready = 4'hF;
        @(posedge clk); #1;
        check("deliver_done_idle", busy, 0);
        @(posedge clk); #1;
        check("next_req_ready", req_ready, 4'b1000);
        check("next_grant_id", grant_id, 3);
        req_valid = 4'b0;
        @(posedge clk); #1;
        check("withdraw_busy", busy, 0);
        check("withdraw_req_ready", req_ready, 0);
        check("withdraw_op_valid", op_valid, 0);

        // Reset while waiting on the adder result
        res_en = 1'b0;
        load_all();
        req_valid = 4'b0100;
        for (c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (res_ready) break;
        end
        check("wr_res_ready_seen", res_ready, 1);
        req_valid = 4'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_res_ready", res_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_op_ab", {op_a, op_b}, 0);
        check("mid_rst_resp", {resp_valid, resp_data}, 0);
        rst_n = 1'b1;
        res_en = 1'b1;
        req_valid = 4'b1001;
        @(posedge clk); #1;
        check("post_rst_req_ready", req_ready, 4'b0001);
        check("post_rst_grant_id", grant_id, 0);
        req_valid = 4'b0;
        @(posedge clk); #1;

        // Requesters 0 and 1 continuously valid
        req_valid = 4'b0011;
        collect(4);
        req_valid = 4'b0;
        for (int k = 0; k < 4; k++) begin
            check("pri_order", got_id[k], exp_pri[k]);
            check("pri_data", got_data[k], psum[exp_pri[k]]);
        end
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares one handshake-wrapped adder datapath among `N_REQ` requesters. Each requester issues an operand pair over a valid/ready port. The block grants one requester at a time, forwards its operands to the shared adder, collects the sum, and returns it on that requester's response port. It sits between the stimulus-side agents and the single adder unit, so only one operation is ever in flight.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `WIDTH`, 32, operand width; result width is `WIDTH+1`

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  reset, synchronous and active-low
- `req_valid`  in  N_REQ  requester i has an operand pair
- `req_ready`  out  N_REQ  one-hot; operand accept for requester i
- `req_a`  in  N_REQ*WIDTH  operand A, requester i at slice [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  operand B, same packing
- `resp_valid`  out  N_REQ  one-hot; result available for requester i
- `resp_ready`  in  N_REQ  requester i accepts its result
- `resp_data`  out  WIDTH+1  result, shared bus; qualified by `resp_valid`
- `op_valid`  out  1  operands presented to the adder
- `op_ready`  in  1  adder accepts operands
- `op_a`, `op_b`  out  WIDTH  latched operands
- `res_valid`  in  1  adder result valid
- `res_ready`  out  1  block accepts adder result
- `res_data`  in  WIDTH+1  adder sum
- `busy`  out  1  high in every state except IDLE
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester

## Operation
- A transfer occurs on any interface at a posedge where valid and ready are both high.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if any `req_valid`, pick winner g (see arbitration), register `grant_id`=g, set `req_ready[g]`=1, go to GRANT.
  - GRANT:
    - If `req_valid[g]`: latch `req_a`/`req_b` slices into `op_a`/`op_b`, clear `req_ready`, set `op_valid`=1, go to ISSUE.
    - If `req_valid[g]` is low: clear `req_ready`, return to IDLE with no pointer update.
  - ISSUE: on `op_valid && op_ready`, clear `op_valid`, set `res_ready`=1, go to WAIT_RES.
  - WAIT_RES: on `res_valid && res_ready`, latch `res_data` into `resp_data`, clear `res_ready`, set `resp_valid[g]`=1, go to DELIVER.
  - DELIVER: on `resp_valid[g] && resp_ready[g]`, clear `resp_valid`, set pointer `last`=g, go to IDLE.
- Arbitration (round-robin): search indices `last+1, last+2, …` modulo `N_REQ`; the first index with `req_valid` set wins.
- The pointer updates only on a completed DELIVER handshake.
- Operands are unsigned. The sum is passed through unmodified (width `WIDTH+1`, carry in the MSB). The block does no arithmetic.
- `req_ready` and `resp_valid` are never high for more than one requester at a time.
- `op_valid`, `res_ready`, and any bit of `resp_valid` are mutually exclusive.
- Requests from other requesters are ignored (their ready stays low) until the block returns to IDLE.

## Timing
- Reset (`rst_n`=0 at a posedge):
  - state IDLE
  - `req_ready`=0, `resp_valid`=0, `op_valid`=0, `res_ready`=0, `busy`=0
  - `grant_id`=0, `resp_data`=0, `op_a`=`op_b`=0
  - `last`=N_REQ-1, so requester 0 has first priority
- Reset mid-operation abandons the transaction. No response is produced and the adder handshake is dropped. The pointer returns to N_REQ-1.
- Minimum latency with `op_ready` held high and `res_valid` arriving the cycle after `res_ready`:
  - `req_ready` high 1 cycle after `req_valid` is seen in IDLE
  - `op_valid` high 1 cycle later
  - `resp_valid` high 4 cycles after `req_valid` is first sampled
- Minimum time from request accepted in IDLE to the next IDLE is 5 cycles.
- Back-pressure on `op_ready`, `res_valid`, or `resp_ready` stalls the FSM indefinitely. Every held output stays stable.
- A `req_valid` that arrives on the same edge as the DELIVER completion is arbitrated in the following IDLE cycle, using the updated pointer.

## Configuration
- `ADDER_ARB_RR_EN` defined: round-robin arbitration as above.
- `ADDER_ARB_RR_EN` undefined:
  - fixed priority; the lowest asserted index always wins
  - `last` is not implemented
  - everything else is unchanged

## Test plan
- Single request: requester 2 sends A=0xFFFF_FFFF, B=1, with an ideal adder → `resp_valid[2]` after 4 cycles, `resp_data`=0x1_0000_0000, `grant_id`=2.
- All four requesters hold `req_valid` from reset → completion order 0,1,2,3, then 0 again; each `resp_data` equals its own A+B.
- `op_ready` held low for 10 cycles in ISSUE → `op_valid`, `op_a`, `op_b` stable; `busy`=1; no `req_ready` to any requester.
- `resp_ready[1]` held low for 8 cycles with requester 3 pending → `resp_valid[1]` held, `req_ready[3]` stays 0; after release, requester 3 is granted next.
- `rst_n` driven low for 1 cycle in WAIT_RES → all outputs at reset values the next cycle; requester 0 wins the next arbitration.
- Build without `ADDER_ARB_RR_EN`, with requesters 0 and 1 continuously valid → requester 0 wins every grant and requester 1 is never served.
